// File: rtl/bram_port_arbiter_pkg.sv
// Shared constants and the read-return tag type for bram_port_arbiter.
// Tag ids are sized for the largest supported requester count (8).
package bram_port_arbiter_pkg;

  localparam int WORD_W     = 32;
  localparam int BYTE_SHIFT = 2;

  localparam logic [3:0] WE_ALL  = 4'hF;
  localparam logic [3:0] WE_NONE = 4'h0;

  localparam int MAX_NREQ = 8;
  localparam int ID_W     = $clog2(MAX_NREQ);

  // One stage of the read-return shift register.
  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } rtag_t;

endpackage

// File: rtl/bram_port_arbiter_rr_arbiter.sv
// Round-robin priority picker: masked priority encoder (double-width rotate).
// Ports: i_req request vector, i_ptr start index; o_gnt one-hot, o_idx binary, o_any.
module bram_port_arbiter_rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [2*N-1:0] w_dbl;
  logic [2*N-1:0] w_rot;
  logic [N-1:0]   w_low;
  logic           w_found;
  int             w_sum;

  // Rotating the doubled vector right by i_ptr puts the
  // highest-priority requester at bit 0.
  always_comb begin
    w_dbl   = {i_req, i_req};
    w_rot   = w_dbl >> i_ptr;
    w_low   = w_rot[N-1:0];
    w_found = 1'b0;
    w_sum   = 0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && w_low[k]) begin
        w_found = 1'b1;
        w_sum   = k + int'(i_ptr);
        if (w_sum >= N) w_sum = w_sum - N;
      end
    end
  end

  assign o_any = w_found;
  assign o_idx = w_found ? IW'(w_sum) : '0;
  assign o_gnt = w_found ? (N'(1) << w_sum) : '0;

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one 32-bit BRAM port among NREQ requesters: round-robin with locked
// bursts (bounded by MAX_BURST) and RD_LAT-deep routing of read returns.
// Ports: clk/rst; i_req/i_we/i_lock/i_addr/i_wdata per requester;
// o_gnt/o_rvalid/o_rdata back to requesters; o_ram_* / i_ram_dout to BRAM.
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int AW        = 16,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        i_req,
  input  logic [NREQ-1:0]        i_we,
  input  logic [NREQ-1:0]        i_lock,
  input  logic [NREQ*AW-1:0]     i_addr,
  input  logic [NREQ*WORD_W-1:0] i_wdata,
  output logic [NREQ-1:0]        o_gnt,
  output logic [NREQ-1:0]        o_rvalid,
  output logic [WORD_W-1:0]      o_rdata,
  output logic [WORD_W-1:0]      o_ram_addr,
  output logic [WORD_W-1:0]      o_ram_din,
  input  logic [WORD_W-1:0]      i_ram_dout,
  output logic                   o_ram_en,
  output logic [3:0]             o_ram_we,
  output logic                   o_ram_clk,
  output logic                   o_ram_rst
);

  localparam int IW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  logic [IW-1:0] r_rr_ptr;
  logic          r_hold_v;
  logic [IW-1:0] r_hold_id;
  logic [BW-1:0] r_burst;
  rtag_t         r_pipe [RD_LAT];

  logic [NREQ-1:0]   w_hold_bit;
  logic              w_others;
  logic              w_hold_req;
  logic              w_at_max;
  logic              w_keep;
  logic              w_force;
  logic [IW-1:0]     w_hold_nxt;
  logic [IW-1:0]     w_arb_ptr;
  logic [NREQ-1:0]   w_arb_gnt;
  logic [IW-1:0]     w_arb_idx;
  logic              w_arb_any;
  logic [NREQ-1:0]   w_gnt;
  logic [IW-1:0]     w_gidx;
  logic              w_any;
  logic              w_beat;
  logic              w_g_we;
  logic              w_g_lock;
  logic [AW-1:0]     w_g_addr;
  logic [IW-1:0]     w_g_next;
  rtag_t             w_ret;

  assign w_hold_bit = NREQ'(1) << r_hold_id;
  assign w_others   = |(i_req & ~w_hold_bit);
  assign w_hold_req = r_hold_v & (|(i_req & w_hold_bit));
  assign w_at_max   = (r_burst >= BW'(MAX_BURST));

  // Holder keeps the port until the burst limit, unless nobody else waits.
  assign w_keep  = w_hold_req & (~w_at_max | ~w_others);
  assign w_force = w_hold_req & w_at_max & w_others;

  assign w_hold_nxt =
    (r_hold_id == IW'(NREQ - 1)) ? '0 : r_hold_id + IW'(1);

  // A starved-out holder drops to lowest priority for this pick.
  assign w_arb_ptr = w_force ? w_hold_nxt : r_rr_ptr;

  bram_port_arbiter_rr_arbiter #(
    .N  (NREQ),
    .IW (IW)
  ) u_rr (
    .i_req (i_req),
    .i_ptr (w_arb_ptr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx),
    .o_any (w_arb_any)
  );

  assign w_gnt  = w_keep ? w_hold_bit : w_arb_gnt;
  assign w_gidx = w_keep ? r_hold_id : w_arb_idx;
  assign w_any  = w_keep | w_arb_any;
  assign w_beat = w_any & ~rst;

  assign w_g_we   = i_we[w_gidx];
  assign w_g_lock = i_lock[w_gidx];
  assign w_g_addr = i_addr[w_gidx*AW +: AW];
  assign w_g_next =
    (w_gidx == IW'(NREQ - 1)) ? '0 : w_gidx + IW'(1);

  assign o_gnt      = w_beat ? w_gnt : '0;
  assign o_ram_en   = w_beat;
  assign o_ram_we   = (w_beat & w_g_we) ? WE_ALL : WE_NONE;
  assign o_ram_addr = WORD_W'(w_g_addr) << BYTE_SHIFT;
  assign o_ram_din  = i_wdata[w_gidx*WORD_W +: WORD_W];
  assign o_ram_clk  = clk;
  assign o_ram_rst  = 1'b0;
  assign o_rdata    = i_ram_dout;

  assign w_ret    = r_pipe[RD_LAT-1];
  assign o_rvalid = (!rst && w_ret.valid) ?
                    (NREQ'(1) << w_ret.id) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr  <= '0;
      r_hold_v  <= 1'b0;
      r_hold_id <= '0;
      r_burst   <= '0;
      for (int s = 0; s < RD_LAT; s++) begin
        r_pipe[s].valid <= 1'b0;
        r_pipe[s].id    <= '0;
      end
    end else begin
      if (w_any) begin
        if (w_g_lock) begin
          r_hold_v  <= 1'b1;
          r_hold_id <= w_gidx;
          if (r_hold_v && r_hold_id == w_gidx)
            r_burst <= w_at_max ? r_burst : r_burst + BW'(1);
          else
            r_burst <= BW'(1);
          if (w_force) r_rr_ptr <= w_hold_nxt;
        end else begin
          r_hold_v <= 1'b0;
          r_burst  <= '0;
          r_rr_ptr <= w_g_next;
        end
      end else if (r_hold_v && !w_hold_req) begin
        // Holder let go of req with nobody else asking.
        r_hold_v <= 1'b0;
        r_burst  <= '0;
      end
      r_pipe[0].valid <= w_any & ~w_g_we;
      r_pipe[0].id    <= ID_W'(w_gidx);
      for (int s = 1; s < RD_LAT; s++)
        r_pipe[s] <= r_pipe[s-1];
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter: reference model of the grant rules,
// behavioural BRAM, and a monitor that checks every read return.
module tb_bram_port_arbiter;

  localparam int NREQ      = 3;
  localparam int AW        = 16;
  localparam int RD_LAT    = 3;
  localparam int MAX_BURST = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      we;
  logic [NREQ-1:0]      lock;
  logic [NREQ*AW-1:0]   addr;
  logic [NREQ*32-1:0]   wdata;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      rvalid;
  logic [31:0]          rdata;
  logic [31:0]          ram_addr;
  logic [31:0]          ram_din;
  logic [31:0]          ram_dout;
  logic                 ram_en;
  logic [3:0]           ram_we;
  logic                 ram_clk;
  logic                 ram_rst;

  always #5 clk = ~clk;

  bram_port_arbiter #(
    .NREQ(NREQ), .AW(AW), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(req), .i_we(we), .i_lock(lock),
    .i_addr(addr), .i_wdata(wdata),
    .o_gnt(gnt), .o_rvalid(rvalid), .o_rdata(rdata),
    .o_ram_addr(ram_addr), .o_ram_din(ram_din),
    .i_ram_dout(ram_dout), .o_ram_en(ram_en),
    .o_ram_we(ram_we), .o_ram_clk(ram_clk), .o_ram_rst(ram_rst)
  );

  function automatic logic [31:0] init_val(int i);
    return 32'hA500_0000 ^ (i * 32'h0001_0203);
  endfunction

  // Behavioural BRAM: 64 words (addresses alias on word bits [5:0]).
  bit          wr_v [64];
  logic [31:0] bmem [64];
  logic [31:0] bp   [RD_LAT];

  always @(posedge clk) begin
    if (ram_en) begin
      bp[0] <= wr_v[ram_addr[7:2]] ? bmem[ram_addr[7:2]]
                                   : init_val(int'(ram_addr[7:2]));
      if (ram_we == 4'hF) begin
        bmem[ram_addr[7:2]] <= ram_din;
        wr_v[ram_addr[7:2]] <= 1'b1;
      end
    end
    for (int s = 1; s < RD_LAT; s++) bp[s] <= bp[s-1];
  end
  assign ram_dout = bp[RD_LAT-1];

  typedef struct {
    int          id;
    logic [31:0] d;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;

  int          m_ptr, m_h, m_cnt;
  bit          m_hv;
  logic [31:0] ref_mem [64];
  logic [AW-1:0] a_addr [NREQ];
  logic [31:0]   a_wd   [NREQ];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: holder keeps the port below MAX_BURST or when alone;
  // otherwise first requester found scanning upward from the pointer
  // (from holder+1 when the holder is being forced off).
  task automatic model(output int g);
    bit others = 0;
    bit forced = 0;
    int start  = m_ptr;
    int idx;
    g = -1;
    for (int j = 0; j < NREQ; j++)
      if (req[j] && !(m_hv && j == m_h)) others = 1;
    if (m_hv && req[m_h]) begin
      if (m_cnt < MAX_BURST || !others) g = m_h;
      else begin
        forced = 1;
        start  = (m_h + 1) % NREQ;
      end
    end
    if (g < 0)
      for (int k = 0; k < NREQ; k++) begin
        idx = (start + k) % NREQ;
        if (g < 0 && req[idx]) g = idx;
      end

    chk("gnt", 32'(gnt), (g >= 0) ? (32'd1 << g) : 32'd0);
    chk("ram_en", 32'(ram_en), (g >= 0) ? 32'd1 : 32'd0);
    if (g >= 0) begin
      chk("ram_we", 32'(ram_we), we[g] ? 32'hF : 32'h0);
      chk("ram_addr", ram_addr, {16'd0, a_addr[g]} * 32'd4);
      if (we[g]) begin
        chk("ram_din", ram_din, a_wd[g]);
        ref_mem[a_addr[g][5:0]] = a_wd[g];
      end else begin
        q.push_back('{g, ref_mem[a_addr[g][5:0]], cyc + RD_LAT});
      end
      if (lock[g]) begin
        m_cnt = (m_hv && g == m_h) ? m_cnt + 1 : 1;
        m_hv  = 1;
        m_h   = g;
        if (forced) m_ptr = start;
      end else begin
        m_hv  = 0;
        m_cnt = 0;
        m_ptr = (g + 1) % NREQ;
      end
    end else begin
      chk("ram_we_idle", 32'(ram_we), 32'h0);
      if (m_hv && !req[m_h]) begin
        m_hv  = 0;
        m_cnt = 0;
      end
    end
  endtask

  task automatic step(input logic [NREQ-1:0] rq, wv, lk,
                      output int g);
    @(negedge clk);
    req  = rq;
    we   = wv;
    lock = lk;
    for (int i = 0; i < NREQ; i++) begin
      addr[i*AW +: AW]  = a_addr[i];
      wdata[i*32 +: 32] = a_wd[i];
    end
    #1;
    model(g);
  endtask

  task automatic do_reset(int n);
    @(negedge clk);
    rst  = 1'b1;
    req  = '0;
    we   = '0;
    lock = '0;
    q.delete();
    m_ptr = 0;
    m_hv  = 0;
    m_h   = 0;
    m_cnt = 0;
    repeat (n) begin
      #1;
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_en", 32'(ram_en), 32'd0);
      chk("rst_we", 32'(ram_we), 32'd0);
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  // Monitor: every cycle the return due now must appear, nothing else.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    if (rst) begin
      chk("rvalid_rst", 32'(rvalid), 32'd0);
    end else if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("rvalid", 32'(rvalid), 32'd1 << e.id);
      chk("rdata", rdata, e.d);
    end else begin
      chk("rvalid_none", 32'(rvalid), 32'd0);
    end
  end

  int              g;
  bit              pend [NREQ];
  logic            pw   [NREQ];
  logic [NREQ-1:0] rq, wv, lk;

  initial begin
    rst   = 1'b1;
    req   = '0;
    we    = '0;
    lock  = '0;
    addr  = '0;
    wdata = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    for (int i = 0; i < NREQ; i++) begin
      a_addr[i] = '0;
      a_wd[i]   = '0;
      pend[i]   = 0;
      pw[i]     = 0;
    end

    do_reset(3);
    chk("ram_rst", 32'(ram_rst), 32'd0);
    repeat (3) step('0, '0, '0, g);

    // Round robin over reads of words 5, 9, 12.
    a_addr[0] = 16'd5;
    a_addr[1] = 16'd9;
    a_addr[2] = 16'd12;
    repeat (4) step(3'b111, 3'b000, 3'b000, g);

    // Write word 7 from requester 1, read it back on requester 0.
    a_addr[1] = 16'd7;
    a_wd[1]   = 32'hDEADBEEF;
    step(3'b010, 3'b010, 3'b000, g);
    a_addr[0] = 16'd7;
    step(3'b001, 3'b000, 3'b000, g);
    repeat (RD_LAT + 1) step('0, '0, '0, g);

    // Locked burst hitting the starvation limit.
    do_reset(1);
    repeat (7) step(3'b101, 3'b000, 3'b001, g);
    step(3'b000, 3'b000, 3'b000, g);

    // Lock release by dropping req while requester 0 waits.
    step(3'b010, 3'b000, 3'b010, g);
    step(3'b011, 3'b000, 3'b010, g);
    step(3'b001, 3'b000, 3'b000, g);

    // Reset with reads in flight.
    step(3'b001, 3'b000, 3'b000, g);
    step(3'b010, 3'b000, 3'b000, g);
    do_reset(1);
    repeat (RD_LAT + 2) step(3'b111, 3'b000, 3'b000, g);

    // Random traffic with held requests.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset(2);
        for (int i = 0; i < NREQ; i++) pend[i] = 0;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i]   = 1;
          pw[i]     = ($urandom_range(0, 3) == 0);
          a_addr[i] = ($urandom_range(0, 7) == 0) ? AW'($urandom)
                                                  : AW'($urandom_range(0, 63));
          a_wd[i]   = $urandom;
        end
        rq[i] = pend[i];
        wv[i] = pw[i];
        lk[i] = pend[i] && ($urandom_range(0, 9) < 7);
      end
      step(rq, wv, lk, g);
      if (g >= 0) pend[g] = 0;
    end

    repeat (RD_LAT + 2) step('0, '0, '0, g);
    chk("drain", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
